// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with forwarding, operand muxing and load-use bubble insertion.
module id_ex_stage #(
  parameter int XLEN = 64,
  parameter int RA_W = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            id_valid,
  input  logic [XLEN-1:0] id_pc,
  input  logic [XLEN-1:0] id_imm,
  input  logic [XLEN-1:0] id_rs1_data,
  input  logic [XLEN-1:0] id_rs2_data,
  input  logic [RA_W-1:0] id_rs1_addr,
  input  logic [RA_W-1:0] id_rs2_addr,
  input  logic [RA_W-1:0] id_rd_addr,
  input  logic            id_rs1_used,
  input  logic            id_rs2_used,
  input  logic            id_rd_wen,
  input  logic            id_is_load,
  input  logic            id_use_pc,
  input  logic            id_use_imm,
  input  logic            id_sub,
  input  logic [3:0]      id_alu_op,
  input  logic            stall_in,
  input  logic            flush_in,
  input  logic [RA_W-1:0] exmem_rd_addr,
  input  logic [RA_W-1:0] memwb_rd_addr,
  input  logic            exmem_rd_wen,
  input  logic            memwb_rd_wen,
  input  logic [XLEN-1:0] exmem_result,
  input  logic [XLEN-1:0] memwb_result,
  output logic            load_use_stall,
  output logic            ex_valid,
  output logic [XLEN-1:0] ex_pc,
  output logic [RA_W-1:0] ex_rd_addr,
  output logic            ex_rd_wen,
  output logic            ex_is_load,
  output logic [XLEN-1:0] alu_a,
  output logic [XLEN-1:0] alu_b,
  output logic [3:0]      alu_op,
  output logic            sub_as_carry,
  output logic [XLEN-1:0] ex_store_data
);
  localparam logic [3:0] alu_add = 4'h0;
  logic [XLEN-1:0] imm_q, rs1_data_q, rs2_data_q, fwd_rs1, fwd_rs2, b0;
  logic [RA_W-1:0] rs1_addr_q, rs2_addr_q;
  logic            use_pc_q, use_imm_q, sub_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid   <= 1'b0;
      ex_pc      <= '0;
      imm_q      <= '0;
      rs1_data_q <= '0;
      rs2_data_q <= '0;
      rs1_addr_q <= '0;
      rs2_addr_q <= '0;
      ex_rd_addr <= '0;
      ex_rd_wen  <= 1'b0;
      ex_is_load <= 1'b0;
      use_pc_q   <= 1'b0;
      use_imm_q  <= 1'b0;
      sub_q      <= 1'b0;
      alu_op     <= 4'h0;
    end else if (flush_in) begin
      ex_valid  <= 1'b0;
      ex_rd_wen <= 1'b0;
    end else if (!stall_in) begin
      ex_valid   <= load_use_stall ? 1'b0 : id_valid;
      ex_pc      <= load_use_stall ? '0 : id_pc;
      imm_q      <= load_use_stall ? '0 : id_imm;
      rs1_data_q <= load_use_stall ? '0 : id_rs1_data;
      rs2_data_q <= load_use_stall ? '0 : id_rs2_data;
      rs1_addr_q <= load_use_stall ? '0 : id_rs1_addr;
      rs2_addr_q <= load_use_stall ? '0 : id_rs2_addr;
      ex_rd_addr <= load_use_stall ? '0 : id_rd_addr;
      ex_rd_wen  <= load_use_stall ? 1'b0 : id_rd_wen;
      ex_is_load <= load_use_stall ? 1'b0 : id_is_load;
      use_pc_q   <= load_use_stall ? 1'b0 : id_use_pc;
      use_imm_q  <= load_use_stall ? 1'b0 : id_use_imm;
      sub_q      <= load_use_stall ? 1'b0 : id_sub;
      alu_op     <= load_use_stall ? alu_add : id_alu_op;
    end
  end
  always_comb begin
    load_use_stall = !flush_in && ex_valid && ex_is_load && ex_rd_wen && (ex_rd_addr != '0) && id_valid &&
                     ((id_rs1_used && id_rs1_addr == ex_rd_addr) || (id_rs2_used && id_rs2_addr == ex_rd_addr));
    // x0 always reads its registered value; EX/MEM has priority over MEM/WB
    fwd_rs1 = (rs1_addr_q == '0) ? rs1_data_q :
              (exmem_rd_wen && exmem_rd_addr == rs1_addr_q) ? exmem_result :
              (memwb_rd_wen && memwb_rd_addr == rs1_addr_q) ? memwb_result : rs1_data_q;
    fwd_rs2 = (rs2_addr_q == '0) ? rs2_data_q :
              (exmem_rd_wen && exmem_rd_addr == rs2_addr_q) ? exmem_result :
              (memwb_rd_wen && memwb_rd_addr == rs2_addr_q) ? memwb_result : rs2_data_q;
    b0            = use_imm_q ? imm_q : fwd_rs2;
    alu_a         = use_pc_q ? ex_pc : fwd_rs1;
    alu_b         = sub_q ? ~b0 : b0;
    sub_as_carry  = sub_q;
    ex_store_data = fwd_rs2;
  end
endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed checks of reset, subtract, forwarding, load-use, stall/flush and operand select.
module tb_id_ex_stage;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        id_valid, id_rs1_used, id_rs2_used, id_rd_wen, id_is_load, id_use_pc, id_use_imm, id_sub;
  logic [63:0] id_pc, id_imm, id_rs1_data, id_rs2_data, exmem_result, memwb_result;
  logic [4:0]  id_rs1_addr, id_rs2_addr, id_rd_addr, exmem_rd_addr, memwb_rd_addr;
  logic [3:0]  id_alu_op, alu_op;
  logic        stall_in, flush_in, exmem_rd_wen, memwb_rd_wen;
  logic        load_use_stall, ex_valid, ex_rd_wen, ex_is_load, sub_as_carry;
  logic [63:0] ex_pc, alu_a, alu_b, ex_store_data;
  logic [4:0]  ex_rd_addr;
  int vecs = 0, errs = 0;

  id_ex_stage dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_pc(id_pc), .id_imm(id_imm),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_rs1_addr(id_rs1_addr),
    .id_rs2_addr(id_rs2_addr), .id_rd_addr(id_rd_addr), .id_rs1_used(id_rs1_used),
    .id_rs2_used(id_rs2_used), .id_rd_wen(id_rd_wen), .id_is_load(id_is_load),
    .id_use_pc(id_use_pc), .id_use_imm(id_use_imm), .id_sub(id_sub), .id_alu_op(id_alu_op),
    .stall_in(stall_in), .flush_in(flush_in), .exmem_rd_addr(exmem_rd_addr),
    .memwb_rd_addr(memwb_rd_addr), .exmem_rd_wen(exmem_rd_wen), .memwb_rd_wen(memwb_rd_wen),
    .exmem_result(exmem_result), .memwb_result(memwb_result), .load_use_stall(load_use_stall),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rd_addr(ex_rd_addr), .ex_rd_wen(ex_rd_wen),
    .ex_is_load(ex_is_load), .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .sub_as_carry(sub_as_carry), .ex_store_data(ex_store_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_id();
    id_valid = 1'b1; id_pc = '0; id_imm = '0; id_rs1_data = '0; id_rs2_data = '0;
    id_rs1_addr = '0; id_rs2_addr = '0; id_rd_addr = '0; id_rs1_used = 1'b0; id_rs2_used = 1'b0;
    id_rd_wen = 1'b0; id_is_load = 1'b0; id_use_pc = 1'b0; id_use_imm = 1'b0; id_sub = 1'b0;
    id_alu_op = 4'h0;
  endtask

  task automatic clr_fwd();
    exmem_rd_addr = '0; memwb_rd_addr = '0; exmem_rd_wen = 1'b0; memwb_rd_wen = 1'b0;
    exmem_result = '0; memwb_result = '0;
  endtask

  initial begin
    stall_in = 1'b0; flush_in = 1'b0;
    clr_fwd();
    clr_id();
    id_rs1_addr = 5'd1; id_rs1_data = 64'd10; id_rs2_addr = 5'd2; id_rs2_data = 64'd3;
    id_rs1_used = 1'b1; id_rs2_used = 1'b1; id_rd_addr = 5'd3; id_rd_wen = 1'b1; id_sub = 1'b1;
    id_pc = 64'h40;
    #12;
    chk("rst_valid", ex_valid, 0);
    chk("rst_rd_wen", ex_rd_wen, 0);
    chk("rst_is_load", ex_is_load, 0);
    chk("rst_lus", load_use_stall, 0);
    chk("rst_alu_a", alu_a, 0);
    chk("rst_alu_b", alu_b, 0);
    chk("rst_alu_op", alu_op, 0);
    chk("rst_carry", sub_as_carry, 0);
    chk("rst_store", ex_store_data, 0);
    rst_n = 1'b1;
    tick();
    chk("sub_valid", ex_valid, 1);
    chk("sub_pc", ex_pc, 64'h40);
    chk("sub_alu_a", alu_a, 64'd10);
    chk("sub_alu_b", alu_b, 64'hFFFF_FFFF_FFFF_FFFC);
    chk("sub_carry", sub_as_carry, 1);
    chk("sub_result", alu_a + alu_b + {63'b0, sub_as_carry}, 64'd7);
    chk("sub_store", ex_store_data, 64'd3);

    clr_id();
    id_rs1_addr = 5'd5; id_rs1_data = 64'h11; id_rs2_addr = 5'd6; id_rs2_data = 64'h22;
    tick();
    exmem_rd_addr = 5'd5; exmem_rd_wen = 1'b1; exmem_result = 64'hAA;
    memwb_rd_addr = 5'd5; memwb_rd_wen = 1'b1; memwb_result = 64'hBB;
    #1 chk("fwd_exmem_wins", alu_a, 64'hAA);
    chk("fwd_rs2_none", alu_b, 64'h22);
    exmem_rd_wen = 1'b0;
    #1 chk("fwd_memwb", alu_a, 64'hBB);
    memwb_rd_addr = 5'd6;
    #1 chk("fwd_reg_rs1", alu_a, 64'h11);
    chk("fwd_rs2_alu_b", alu_b, 64'hBB);
    chk("fwd_rs2_store", ex_store_data, 64'hBB);
    clr_fwd();
    clr_id();
    tick();
    exmem_rd_addr = 5'd0; exmem_rd_wen = 1'b1; exmem_result = 64'hAA;
    memwb_rd_addr = 5'd0; memwb_rd_wen = 1'b1; memwb_result = 64'hBB;
    #1 chk("fwd_x0", alu_a, 64'h0);
    clr_fwd();

    clr_id();
    id_is_load = 1'b1; id_rd_addr = 5'd7; id_rd_wen = 1'b1; id_pc = 64'h100;
    tick();
    chk("ld_in_ex", ex_is_load, 1);
    clr_id();
    id_rd_addr = 5'd8; id_rd_wen = 1'b1; id_rs2_used = 1'b1; id_rs2_addr = 5'd7;
    id_alu_op = 4'h3; id_pc = 64'h104;
    #1 chk("lu_detect", load_use_stall, 1);
    tick();
    chk("bubble_valid", ex_valid, 0);
    chk("bubble_rd_wen", ex_rd_wen, 0);
    chk("bubble_alu_op", alu_op, 0);
    chk("bubble_lus_clear", load_use_stall, 0);
    tick();
    chk("lu_enter_valid", ex_valid, 1);
    chk("lu_enter_rd", ex_rd_addr, 5'd8);
    chk("lu_enter_op", alu_op, 4'h3);

    id_pc = 64'h108; id_rd_addr = 5'd9; stall_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_pc", ex_pc, 64'h104);
      chk("stall_rd", ex_rd_addr, 5'd8);
    end
    stall_in = 1'b0;
    tick();
    chk("unstall_pc", ex_pc, 64'h108);

    clr_id();
    id_is_load = 1'b1; id_rd_addr = 5'd7; id_rd_wen = 1'b1; id_pc = 64'h10C;
    tick();
    clr_id();
    id_rs1_used = 1'b1; id_rs1_addr = 5'd7; id_pc = 64'h110; stall_in = 1'b1;
    #1 chk("stall_lu_detect", load_use_stall, 1);
    tick();
    chk("stall_lu_hold_pc", ex_pc, 64'h10C);
    chk("stall_lu_hold_ld", ex_is_load, 1);
    chk("stall_lu_kept", load_use_stall, 1);
    flush_in = 1'b1;
    #1 chk("flush_masks_lu", load_use_stall, 0);
    tick();
    chk("flush_valid", ex_valid, 0);
    chk("flush_rd_wen", ex_rd_wen, 0);
    flush_in = 1'b0; stall_in = 1'b0;
    tick();
    chk("post_flush_valid", ex_valid, 1);
    chk("post_flush_pc", ex_pc, 64'h110);

    clr_id();
    id_use_pc = 1'b1; id_use_imm = 1'b1; id_pc = 64'h8000_0000; id_imm = 64'd4;
    id_rs2_addr = 5'd9; id_rs2_data = 64'h55;
    tick();
    memwb_rd_addr = 5'd9; memwb_rd_wen = 1'b1; memwb_result = 64'h77;
    #1 chk("sel_alu_a", alu_a, 64'h8000_0000);
    chk("sel_alu_b", alu_b, 64'd4);
    chk("sel_store", ex_store_data, 64'h77);
    clr_fwd();

    stall_in = 1'b1;
    tick();
    chk("pre_rst_valid", ex_valid, 1);
    rst_n = 1'b0;
    #1 chk("midstall_rst_valid", ex_valid, 0);
    chk("midstall_rst_alu_a", alu_a, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
